// File: rtl/adc_averager.sv
// Sliding-window averager for XADC DRP samples: a 2^LOG2_N entry circular buffer with a
// running sum, giving a registered truncated mean once the window has filled.
module adc_averager #(
    parameter int unsigned LOG2_N = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DRDY,
    input  logic [15:0] DO,
    input  logic        CLR,
    output logic [11:0] V_AVG,
    output logic        AVG_VALID,
    output logic        WIN_FULL,
    output logic        BUSY,
    output logic        DROP
);

    localparam int unsigned N    = 1 << LOG2_N;
    localparam int unsigned SumW = 12 + LOG2_N;

    localparam logic [LOG2_N-1:0] PtrLast  = LOG2_N'(N - 1);
    localparam logic [LOG2_N:0]   FillLast = (LOG2_N + 1)'(N - 1);

    typedef enum logic [1:0] {
        StFill,
        StRun,
        StClear
    } state_e;

    state_e            state_q, state_d;
    logic [11:0]       sample_buf_q [N];
    logic [LOG2_N-1:0] ptr_q, ptr_d;
    logic [LOG2_N:0]   fill_q, fill_d;
    logic [SumW-1:0]   sum_q, sum_d;
    logic [11:0]       avg_q, avg_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              drop_q, drop_d;

    logic              buf_we;
    logic [11:0]       buf_wdata;
    logic [11:0]       sample;
    logic [SumW-1:0]   sum_next;
    logic [LOG2_N-1:0] ptr_inc;

    // The four LSBs of the DRP word carry no conversion data.
    logic              unused_do_lsb;
    assign unused_do_lsb = ^DO[3:0];

    assign sample = DO[15:4];

    // The outgoing entry is already part of sum_q, so this cannot underflow.
    assign sum_next = sum_q + SumW'(sample) - SumW'(sample_buf_q[ptr_q]);
    assign ptr_inc  = ptr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        fill_d    = fill_q;
        sum_d     = sum_q;
        avg_d     = avg_q;
        valid_d   = 1'b0;
        full_d    = full_q;
        drop_d    = 1'b0;
        buf_we    = 1'b0;
        buf_wdata = sample;

        if (CLR) begin
            // Clear wins over any sample presented in the same cycle.
            state_d = StClear;
            ptr_d   = '0;
            fill_d  = '0;
            sum_d   = '0;
            avg_d   = '0;
            full_d  = 1'b0;
            drop_d  = DRDY;
        end else begin
            unique case (state_q)
                StClear: begin
                    drop_d    = DRDY;
                    buf_we    = 1'b1;
                    buf_wdata = '0;
                    ptr_d     = ptr_inc;
                    if (ptr_q == PtrLast) begin
                        state_d = StFill;
                    end
                end
                StFill: begin
                    if (DRDY) begin
                        buf_we = 1'b1;
                        sum_d  = sum_next;
                        ptr_d  = ptr_inc;
                        fill_d = fill_q + 1'b1;
                        if (fill_q == FillLast) begin
                            state_d = StRun;
                            full_d  = 1'b1;
                            valid_d = 1'b1;
                            avg_d   = sum_next[SumW-1:LOG2_N];
                        end
                    end
                end
                StRun: begin
                    if (DRDY) begin
                        buf_we  = 1'b1;
                        sum_d   = sum_next;
                        ptr_d   = ptr_inc;
                        valid_d = 1'b1;
                        avg_d   = sum_next[SumW-1:LOG2_N];
                    end
                end
                default: begin
                    state_d = StFill;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StFill;
            ptr_q   <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N; i++) begin
                sample_buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            sample_buf_q[ptr_q] <= buf_wdata;
        end
    end

    assign V_AVG     = avg_q;
    assign AVG_VALID = valid_q;
    assign WIN_FULL  = full_q;
    assign BUSY      = (state_q == StClear);
    assign DROP      = drop_q;

endmodule

// File: doc/adc_averager.md
ADC_AVERAGER -- requirements
Module: adc_averager

Interface
REQ-001 SHALL have parameter LOG2_N, default 3, log2 of averaging window depth (legal 1..4; window N = 2^LOG2_N samples).
REQ-002 SHALL have port CLK  input  1  single clock; all logic is rising-edge on CLK (PLL clock domain).
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port DRDY  input  1  XADC DRP data-ready strobe; one-cycle pulse per conversion.
REQ-005 SHALL have port DO  input  16  XADC DRP read data; sample = DO[15:4].
REQ-006 SHALL have port CLR  input  1  synchronous window clear request, level-sampled each cycle.
REQ-007 SHALL have port V_AVG  output  12  registered window average, feeds the voltage comparator and FF array in place of raw V_in.
REQ-008 SHALL have port AVG_VALID  output  1  one-cycle pulse, V_AVG updated this cycle.
REQ-009 SHALL have port WIN_FULL  output  1  high once N samples have entered since the last reset/clear.
REQ-010 SHALL have port BUSY  output  1  high while the window clear walk is in progress.
REQ-011 SHALL have port DROP  output  1  one-cycle pulse, a DRDY sample was discarded.

Function
REQ-012 SHALL hold an N-entry circular sample buffer (12 bits/entry), a write pointer (LOG2_N bits), a fill counter (LOG2_N+1 bits), and a running sum of 12+LOG2_N bits; the sum never overflows.
REQ-013 SHALL implement states FILL, RUN, CLEAR; FILL = window not yet full, RUN = window full, CLEAR = zeroing buffer.
REQ-014 SHALL, on an accepted sample (DRDY=1 in FILL or RUN with CLR=0): sum <= sum + sample - buf[ptr]; buf[ptr] <= sample; ptr <= ptr+1 wrapping N-1 -> 0.
REQ-015 SHALL, in FILL, increment the fill counter per accepted sample and transition to RUN on the Nth sample; WIN_FULL asserts in the same cycle as the RUN transition.
REQ-016 SHALL keep AVG_VALID low and V_AVG unchanged while in FILL, except on the Nth sample.
REQ-017 SHALL, on each accepted sample that completes or follows window fill, register V_AVG = (updated sum) >> LOG2_N (truncation) and pulse AVG_VALID, both one cycle after the DRDY cycle (latency 1).
REQ-018 SHALL accept DRDY on every consecutive cycle (throughput 1 sample/cycle); back-to-back DRDY yields back-to-back AVG_VALID in RUN.
REQ-019 SHALL, when CLR=1 in any state: enter CLEAR, set sum=0, ptr=0, fill counter=0, V_AVG=0, WIN_FULL=0.
REQ-020 SHALL, in CLEAR, write buf[ptr]=0 and increment ptr each cycle; after writing entry N-1, ptr wraps to 0 and state goes to FILL (CLEAR lasts exactly N cycles); BUSY=1 for exactly those cycles.
REQ-021 SHALL, when CLR is asserted again during CLEAR, restart the walk from ptr=0.
REQ-022 SHALL discard DRDY when in CLEAR or when CLR=1 in the same cycle (CLR has priority) and pulse DROP one cycle later; no state other than DROP changes due to the discarded sample.
REQ-023 SHALL ignore DO when DRDY=0.

Reset
REQ-024 SHALL, on RST=0, immediately (asynchronously) set state=FILL, all buffer entries=0, sum=0, ptr=0, fill counter=0, V_AVG=0, AVG_VALID=0, WIN_FULL=0, BUSY=0, DROP=0.
REQ-025 SHALL resume operation on the first rising CLK edge after RST returns high, accepting a DRDY on that edge.

Verification (LOG2_N=3)
REQ-026 SHALL cover: reset, 8 DRDY with DO=16'h8000 -> no AVG_VALID for first 7; on cycle after 8th, AVG_VALID=1, V_AVG=12'h800, WIN_FULL=1.
REQ-027 SHALL cover: continuing from REQ-026, 4 DRDY with DO=16'hFFF0 -> V_AVG=12'hBFF after 4th; 4 more -> V_AVG=12'hFFF; sum peak 15'h7FF8, no overflow.
REQ-028 SHALL cover: DRDY held high 20 cycles in RUN with incrementing samples -> AVG_VALID high 20 consecutive cycles, each V_AVG equals truncated mean of last 8 samples (scoreboard).
REQ-029 SHALL cover: in RUN, CLR pulse for 1 cycle with DRDY also high -> DROP pulse next cycle, BUSY high exactly 8 cycles, V_AVG=0, WIN_FULL=0; DRDY during BUSY -> DROP pulse each, then 8 fresh samples of 12'h100 -> V_AVG=12'h100.
REQ-030 SHALL cover: RST driven low mid-cycle in RUN (between edges) -> all outputs 0 before next edge; after release, fill sequence per REQ-026 repeats identically.
